// File: rtl/quad_encoder_emulator.sv
// Quadrature A/B encoder emulator. It emits edges at a commanded period and direction and tracks its own position.
// The optional index output is enabled by defining QUAD_EMU_INDEX_EN.
module quad_encoder_emulator #(
  parameter int COUNTS_PER_REV = 1496,
  parameter int PERIOD_W       = 16,
  parameter int MIN_PERIOD     = 16,
  parameter int POS_W          = 13
) (
  input  logic                Clk,
  input  logic                i_rst,
  input  logic                i_Load,
  input  logic [PERIOD_W-1:0] i_Period,
  input  logic                i_Dir,
  output logic                o_A,
  output logic                o_B,
  output logic                o_Edge,
  output logic [POS_W-1:0]    o_Position,
  output logic                o_Running,
  output logic                o_Index
);

  // Phase states are encoded directly as their {A,B} levels.
  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b10;
  localparam logic [1:0] S2 = 2'b11;
  localparam logic [1:0] S3 = 2'b01;

  localparam logic [PERIOD_W-1:0] MIN_P   = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] ONE_P   = {{(PERIOD_W-1){1'b0}}, 1'b1};
  localparam logic [POS_W-1:0]    POS_MAX = POS_W'(COUNTS_PER_REV - 1);
  localparam logic [POS_W-1:0]    ONE_POS = {{(POS_W-1){1'b0}}, 1'b1};

  function automatic logic [1:0] step_phase(input logic [1:0] ab, input logic cw);
    case (ab)
      S0:      step_phase = cw ? S1 : S3;
      S1:      step_phase = cw ? S2 : S0;
      S2:      step_phase = cw ? S3 : S1;
      S3:      step_phase = cw ? S0 : S2;
      default: step_phase = S0;
    endcase
  endfunction

  logic [1:0]          ab_r, ab_s;
  logic                edge_r, edge_s;
  logic [POS_W-1:0]    pos_r, pos_s;
  logic                run_r;
  logic [PERIOD_W-1:0] active_r, active_s;
  logic [PERIOD_W-1:0] cnt_r, cnt_s;
  logic [PERIOD_W-1:0] shadow_period_r, shadow_period_s;
  logic                shadow_dir_r, shadow_dir_s;

  // Shadow capture: short nonzero periods are clamped so the debouncer always sees settled levels.
  always_comb begin
    shadow_period_s = shadow_period_r;
    shadow_dir_s    = shadow_dir_r;
    if (i_Load) begin
      shadow_period_s = ((i_Period != '0) && (i_Period < MIN_P)) ? MIN_P : i_Period;
      shadow_dir_s    = i_Dir;
    end else begin
      shadow_period_s = shadow_period_r;
      shadow_dir_s    = shadow_dir_r;
    end
  end

  // Edge timing: the shadow period and direction take effect only at edge boundaries, or on leaving STOPPED.
  always_comb begin
    edge_s   = 1'b0;
    cnt_s    = cnt_r;
    active_s = active_r;
    ab_s     = ab_r;
    pos_s    = pos_r;
    if (active_r == '0) begin
      cnt_s    = '0;
      active_s = shadow_period_r;
    end else if (cnt_r == (active_r - ONE_P)) begin
      edge_s   = 1'b1;
      cnt_s    = '0;
      active_s = shadow_period_r;
      ab_s     = step_phase(ab_r, shadow_dir_r);
      if (shadow_dir_r) begin
        pos_s = (pos_r == POS_MAX) ? '0 : pos_r + ONE_POS;
      end else begin
        pos_s = (pos_r == '0) ? POS_MAX : pos_r - ONE_POS;
      end
    end else begin
      cnt_s = cnt_r + ONE_P;
    end
  end

  // State registers. Reset overrides any simultaneous load.
  always_ff @(posedge Clk) begin
    if (i_rst) begin
      ab_r            <= S0;
      edge_r          <= 1'b0;
      pos_r           <= '0;
      run_r           <= 1'b0;
      active_r        <= '0;
      cnt_r           <= '0;
      shadow_period_r <= '0;
      shadow_dir_r    <= 1'b1;
    end else begin
      ab_r            <= ab_s;
      edge_r          <= edge_s;
      pos_r           <= pos_s;
      run_r           <= (active_s != '0);
      active_r        <= active_s;
      cnt_r           <= cnt_s;
      shadow_period_r <= shadow_period_s;
      shadow_dir_r    <= shadow_dir_s;
    end
  end

`ifdef QUAD_EMU_INDEX_EN
  logic index_r;

  // The index is registered from the next position so it stays aligned with A/B.
  always_ff @(posedge Clk) begin
    if (i_rst) begin
      index_r <= 1'b1;
    end else begin
      index_r <= (pos_s == '0);
    end
  end

  assign o_Index = index_r;
`else
  assign o_Index = 1'b0;
`endif

  assign o_A        = ab_r[1];
  assign o_B        = ab_r[0];
  assign o_Edge     = edge_r;
  assign o_Position = pos_r;
  assign o_Running  = run_r;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Directed, table-driven bench for quad_encoder_emulator. Hand sequences cover the wrap and the reset corner cases.
module tb_quad_encoder_emulator;

`ifdef QUAD_EMU_INDEX_EN
  localparam bit INDEX_EN = 1'b1;
`else
  localparam bit INDEX_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_Load = 1'b0;
  logic [15:0] i_Period = 16'd0;
  logic        i_Dir = 1'b0;
  logic        o_A, o_B, o_Edge, o_Running, o_Index;
  logic [12:0] o_Position;

  int n_vec = 0;
  int n_bad = 0;

  quad_encoder_emulator dut (
    .Clk(Clk), .i_rst(i_rst), .i_Load(i_Load), .i_Period(i_Period), .i_Dir(i_Dir),
    .o_A(o_A), .o_B(o_B), .o_Edge(o_Edge), .o_Position(o_Position),
    .o_Running(o_Running), .o_Index(o_Index)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        load;
    logic [15:0] period;
    logic        dir;
    int          wait_n;
    logic [1:0]  ab;
    logic [12:0] pos;
    logic        edge_v;
    logic        run;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic exp_idx(input logic [12:0] pos);
    return INDEX_EN && (pos == 13'd0);
  endfunction

  function automatic logic [1:0] cw_next(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [1:0]  m_ab;
    logic [12:0] m_pos;
    int          cyc;
    logic        bad_idx;
    int          edges;

    //             load  period  dir  wait  {A,B}  pos       edge  run
    vecs[0]  = '{1'b1, 16'd20, 1'b1, 20, 2'b00, 13'd0,    1'b0, 1'b1};
    vecs[1]  = '{1'b0, 16'd0,  1'b0, 1,  2'b10, 13'd1,    1'b1, 1'b1};
    vecs[2]  = '{1'b0, 16'd0,  1'b0, 1,  2'b10, 13'd1,    1'b0, 1'b1};
    vecs[3]  = '{1'b0, 16'd0,  1'b0, 19, 2'b11, 13'd2,    1'b1, 1'b1};
    vecs[4]  = '{1'b0, 16'd0,  1'b0, 20, 2'b01, 13'd3,    1'b1, 1'b1};
    vecs[5]  = '{1'b0, 16'd0,  1'b0, 20, 2'b00, 13'd4,    1'b1, 1'b1};
    vecs[6]  = '{1'b0, 16'd0,  1'b0, 5,  2'b00, 13'd4,    1'b0, 1'b1};
    vecs[7]  = '{1'b1, 16'd20, 1'b0, 13, 2'b00, 13'd4,    1'b0, 1'b1};
    vecs[8]  = '{1'b0, 16'd0,  1'b0, 1,  2'b01, 13'd3,    1'b1, 1'b1};
    vecs[9]  = '{1'b0, 16'd0,  1'b0, 20, 2'b11, 13'd2,    1'b1, 1'b1};
    vecs[10] = '{1'b1, 16'd5,  1'b0, 19, 2'b10, 13'd1,    1'b1, 1'b1};
    vecs[11] = '{1'b0, 16'd0,  1'b0, 15, 2'b10, 13'd1,    1'b0, 1'b1};
    vecs[12] = '{1'b0, 16'd0,  1'b0, 1,  2'b00, 13'd0,    1'b1, 1'b1};
    vecs[13] = '{1'b1, 16'd0,  1'b0, 15, 2'b01, 13'd1495, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 16'd0,  1'b0, 40, 2'b01, 13'd1495, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 16'd16, 1'b1, 17, 2'b00, 13'd0,    1'b1, 1'b1};

    repeat (3) tick();
    i_rst = 1'b0;
    check("reset", {o_A, o_B, o_Position, o_Edge, o_Running, o_Index},
          {2'b00, 13'd0, 1'b0, 1'b0, exp_idx(13'd0)});

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].load) begin
        i_Load = 1'b1; i_Period = vecs[i].period; i_Dir = vecs[i].dir;
        tick();
        i_Load = 1'b0;
      end
      repeat (vecs[i].wait_n) tick();
      check($sformatf("vec%0d", i), {o_A, o_B, o_Position, o_Edge, o_Running, o_Index},
            {vecs[i].ab, vecs[i].pos, vecs[i].edge_v, vecs[i].run, exp_idx(vecs[i].pos)});
    end

    // The bench now sits on a CW edge at position 0 with P=16. Run a full revolution.
    m_ab  = 2'b00;
    m_pos = 13'd0;
    for (int e = 0; e < 1496; e++) begin
      cyc = 0;
      bad_idx = 1'b0;
      do begin
        tick();
        cyc++;
        if (!o_Edge && (o_Index !== exp_idx(m_pos))) bad_idx = 1'b1;
      end while (!o_Edge && cyc < 64);
      m_ab  = cw_next(m_ab);
      m_pos = (m_pos == 13'd1495) ? 13'd0 : m_pos + 13'd1;
      if (o_Index !== exp_idx(m_pos)) bad_idx = 1'b1;
      check($sformatf("wrap_edge%0d", e), {cyc[7:0], o_A, o_B, o_Position, bad_idx},
            {8'd16, m_ab, m_pos, 1'b0});
    end

    // A reset together with a load must win, and no edge may follow.
    repeat (5) tick();
    i_rst = 1'b1; i_Load = 1'b1; i_Period = 16'd30; i_Dir = 1'b0;
    tick();
    i_rst = 1'b0; i_Load = 1'b0;
    check("rst_with_load", {o_A, o_B, o_Position, o_Edge, o_Running, o_Index},
          {2'b00, 13'd0, 1'b0, 1'b0, exp_idx(13'd0)});
    edges = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (o_Edge || o_Running || o_A || o_B) edges++;
    end
    check("no_edge_after_rst", edges, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
